// File: rtl/cabac_se_mvd_sched.sv
// ---------------------------------------------------------------------------
// cabac_se_mvd_sched
//
// Purpose:
//   Per-PU scheduler for the mvd-related CABAC syntax elements of one inter
//   PU. It latches the mvds and mvp indices of both reference lists, then
//   walks the mvd_coding order for L0 followed by L1. For each list the order
//   is g0x, g0y, g1x, g1y, m2x, signx, m2y, signy, mvp. Pairs that are absent
//   for the current mvd are skipped by a same-cycle priority search, so they
//   cost no cycles. Surviving pairs go out one per cycle under valid/ready.
//
// Pair layout (PAIR_W = 23): [22:13] value, [12:9] bin count, [8:0] ctx id.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_i           PU request, taken only while start_ready_o is high
//   start_ready_o     high in IDLE
//   inter_dir_i       01=L0, 10=L1, 11=BI, 00=no mvd
//   mv_l0_i/mv_l1_i   {mvd_x, mvd_y} per list, two's complement
//   mvp_idx_l0_i/l1_i mvp indices
//   se_pair_o         current SE pair
//   se_valid_o        pair valid
//   se_ready_i        downstream accepts
//   busy_o            high whenever the FSM is not IDLE
//   done_o            one-cycle pulse after the PU has finished
//   pair_cnt_o        (only with CABAC_MVD_STAT_EN) count of transferred
//                     pairs since reset, saturating at 16'hFFFF
//
// Optional build macro: CABAC_MVD_STAT_EN adds pair_cnt_o and its counter.
// ---------------------------------------------------------------------------
module cabac_se_mvd_sched #(
  parameter int MVD_W  = 11,
  parameter int PAIR_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 start_ready_o,
  input  logic [1:0]           inter_dir_i,
  input  logic [2*MVD_W-1:0]   mv_l0_i,
  input  logic [2*MVD_W-1:0]   mv_l1_i,
  input  logic [2:0]           mvp_idx_l0_i,
  input  logic [2:0]           mvp_idx_l1_i,
  output logic [PAIR_W-1:0]    se_pair_o,
  output logic                 se_valid_o,
  input  logic                 se_ready_i,
  output logic                 busy_o,
  output logic                 done_o
`ifdef CABAC_MVD_STAT_EN
  ,
  output logic [15:0]          pair_cnt_o
`endif
);

  localparam int VAL_W = PAIR_W - 13;

  localparam logic [3:0] CNT1    = 4'h1;
  localparam logic [8:0] ID_G0   = 9'h016;
  localparam logic [8:0] ID_G1   = 9'h017;
  localparam logic [8:0] ID_M2   = 9'h0BE;
  localparam logic [8:0] ID_SIGN = 9'h0BB;
  localparam logic [8:0] ID_MVP  = 9'h0B0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT_L0,
    S_EMIT_L1,
    S_DONE
  } state_t;

  // Builds a pair whose value is a single flag bit, zero-extended.
  function automatic logic [PAIR_W-1:0] flagPair(input logic flag, input logic [8:0] id);
    flagPair = {{(VAL_W-1){1'b0}}, flag, CNT1, id};
  endfunction

  // Two's-complement magnitude. The illegal -2^(MVD_W-1) maps to 2^(MVD_W-1),
  // which still has the right bit pattern for the wrapped m2 value.
  function automatic logic [MVD_W-1:0] absOf(input logic [MVD_W-1:0] v);
    absOf = v[MVD_W-1] ? (~v + 1'b1) : v;
  endfunction

  state_t               r_state;
  logic [2*MVD_W-1:0]   r_mvL0;
  logic [2*MVD_W-1:0]   r_mvL1;
  logic [2:0]           r_mvpL0;
  logic [2:0]           r_mvpL1;
  logic                 r_hasL1;
  logic [3:0]           r_slot;
  logic [PAIR_W-1:0]    r_pair;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_startReady;

  logic [2*MVD_W-1:0]   w_mv      [2];
  logic [MVD_W-1:0]     w_comp    [2][2];
  logic [MVD_W-1:0]     w_abs     [2][2];
  logic                 w_g0      [2][2];
  logic                 w_g1      [2][2];
  logic                 w_sign    [2][2];
  logic [VAL_W-1:0]     w_m2      [2][2];
  logic                 w_mvpNz   [2];
  logic [8:0]           w_mask    [2];
  logic [PAIR_W-1:0]    w_slotPair[2][9];

  logic                 w_curList;
  logic                 w_found;
  logic [3:0]           w_nextSlot;
  logic [PAIR_W-1:0]    w_nextPair;
  logic                 w_xfer;

  assign w_mv[0]    = r_mvL0;
  assign w_mv[1]    = r_mvL1;
  assign w_mvpNz[0] = |r_mvpL0;
  assign w_mvpNz[1] = |r_mvpL1;

  // Per list and component: greater0/greater1 flags, sign and the
  // abs-minus-two remainder, all from the latched mvds. Index c: 0=x, 1=y.
  for (genvar l = 0; l < 2; l++) begin : gList
    for (genvar c = 0; c < 2; c++) begin : gComp
      assign w_comp[l][c] = (c == 0) ? w_mv[l][2*MVD_W-1:MVD_W] : w_mv[l][MVD_W-1:0];
      assign w_abs[l][c]  = absOf(w_comp[l][c]);
      assign w_g0[l][c]   = |w_comp[l][c];
      assign w_g1[l][c]   = |w_abs[l][c][MVD_W-1:1];
      assign w_sign[l][c] = w_comp[l][c][MVD_W-1];
      assign w_m2[l][c]   = w_abs[l][c][VAL_W-1:0] - VAL_W'(2);
    end

    // Presence mask in slot order (bit 0 = g0x ... bit 8 = mvp).
    assign w_mask[l] = {1'b1, w_g0[l][1], w_g1[l][1], w_g0[l][0], w_g1[l][0],
                        w_g0[l][1], w_g0[l][0], 1'b1, 1'b1};

    assign w_slotPair[l][0] = flagPair(w_g0[l][0], ID_G0);
    assign w_slotPair[l][1] = flagPair(w_g0[l][1], ID_G0);
    assign w_slotPair[l][2] = flagPair(w_g1[l][0], ID_G1);
    assign w_slotPair[l][3] = flagPair(w_g1[l][1], ID_G1);
    assign w_slotPair[l][4] = {w_m2[l][0], CNT1, ID_M2};
    assign w_slotPair[l][5] = flagPair(w_sign[l][0], ID_SIGN);
    assign w_slotPair[l][6] = {w_m2[l][1], CNT1, ID_M2};
    assign w_slotPair[l][7] = flagPair(w_sign[l][1], ID_SIGN);
    assign w_slotPair[l][8] = flagPair(w_mvpNz[l], ID_MVP);
  end

  assign w_curList = (r_state == S_EMIT_L1);
  assign w_xfer    = r_valid & se_ready_i;

  // Priority search for the lowest present slot after the one currently on
  // the output. The loop runs high to low so the lowest match wins. When
  // nothing is found, the current list is exhausted.
  always_comb begin
    w_found    = 1'b0;
    w_nextSlot = '0;
    w_nextPair = '0;
    for (int i = 8; i >= 0; i--) begin
      if ((4'(i) > r_slot) && w_mask[w_curList][i]) begin
        w_found    = 1'b1;
        w_nextSlot = 4'(i);
        w_nextPair = w_slotPair[w_curList][i];
      end
    end
  end

  // Main FSM with registered outputs. At start the first pair is built
  // straight from the input ports, because the latches only become valid on
  // the same edge. This gives the one-cycle start-to-valid latency. g0x is
  // always present, so every list begins at slot 0. When L0 runs out, the FSM
  // loads L1's g0x on the same edge, so no bubble appears between the lists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mvL0       <= '0;
      r_mvL1       <= '0;
      r_mvpL0      <= '0;
      r_mvpL1      <= '0;
      r_hasL1      <= 1'b0;
      r_slot       <= '0;
      r_pair       <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_startReady <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mvL0       <= mv_l0_i;
            r_mvL1       <= mv_l1_i;
            r_mvpL0      <= mvp_idx_l0_i;
            r_mvpL1      <= mvp_idx_l1_i;
            r_hasL1      <= inter_dir_i[1];
            r_slot       <= '0;
            r_busy       <= 1'b1;
            r_startReady <= 1'b0;
            if (inter_dir_i[0]) begin
              r_state <= S_EMIT_L0;
              r_valid <= 1'b1;
              r_pair  <= flagPair(|mv_l0_i[2*MVD_W-1:MVD_W], ID_G0);
            end else if (inter_dir_i[1]) begin
              r_state <= S_EMIT_L1;
              r_valid <= 1'b1;
              r_pair  <= flagPair(|mv_l1_i[2*MVD_W-1:MVD_W], ID_G0);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_EMIT_L0, S_EMIT_L1: begin
          if (w_xfer) begin
            if (w_found) begin
              r_slot <= w_nextSlot;
              r_pair <= w_nextPair;
            end else if ((r_state == S_EMIT_L0) && r_hasL1) begin
              r_state <= S_EMIT_L1;
              r_slot  <= '0;
              r_pair  <= w_slotPair[1][0];
            end else begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_pair  <= '0;
              r_done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state      <= S_IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_startReady <= 1'b1;
        end

        default: begin
          r_state      <= S_IDLE;
          r_valid      <= 1'b0;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_startReady <= 1'b1;
        end
      endcase
    end
  end

  assign se_pair_o     = r_pair;
  assign se_valid_o    = r_valid;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign start_ready_o = r_startReady;

`ifdef CABAC_MVD_STAT_EN
  logic [15:0] r_pairCnt;

  // Counts every accepted pair. The count sticks at all-ones instead of
  // wrapping, so a long run never reads back as a small number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pairCnt <= '0;
    end else if (w_xfer && (r_pairCnt != 16'hFFFF)) begin
      r_pairCnt <= r_pairCnt + 16'd1;
    end
  end

  assign pair_cnt_o = r_pairCnt;
`endif

endmodule

// File: doc/cabac_se_mvd_sched.md
Name: cabac_se_mvd_sched

Overview:
- Per-PU scheduler that serializes the mvd-related CABAC syntax-element pairs for one inter PU into the downstream binarizer.
- Latches both lists' mvds and mvp indices, then generates pairs per list (L0 then L1) in HEVC mvd_coding order, followed by the mvp flag.
- Pairs that are absent for the current mvd are dropped and cost no cycles.
- Surviving pairs are emitted one per cycle under a valid/ready handshake.

Parameters:
- MVD_W, 11, signed mvd component width (two's complement).
- PAIR_W, 23, SE-pair width: [22:13] value, [12:9] bin count, [8:0] ctx/type id.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start_i  in  1  PU request; accepted only when start_ready_o=1
- start_ready_o  out  1  high in IDLE
- inter_dir_i  in  2  01=L0, 10=L1, 11=BI, 00=no mvd
- mv_l0_i  in  2*MVD_W  {mvd_x, mvd_y} for L0
- mv_l1_i  in  2*MVD_W  {mvd_x, mvd_y} for L1
- mvp_idx_l0_i  in  3  L0 mvp index
- mvp_idx_l1_i  in  3  L1 mvp index
- se_pair_o  out  PAIR_W  current pair
- se_valid_o  out  1  pair valid
- se_ready_i  in  1  downstream accepts
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse after PU finished

Behaviour:
- Reset: state IDLE, se_valid_o=0, se_pair_o=0, done_o=0, busy_o=0, start_ready_o=1, internal latches=0.
- States:
  - IDLE: on start_i, latch all inputs. Next state: EMIT_L0 if inter_dir[0]; else EMIT_L1 if inter_dir[1]; else DONE.
  - EMIT_L0: after the last present pair is accepted, go to EMIT_L1 if inter_dir[1], else DONE.
  - EMIT_L1: after the last present pair is accepted, go to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- Latency: start accepted at cycle t, first se_valid_o at t+1.
- Per-list derivation (x, y components; abs = two's-complement magnitude):
  - g0 = (mvd != 0); g1 = (abs[10:1] != 0); sign = bit 10; m2 = abs[9:0] - 2, mod 1024.
- Pair encodings ({value, cnt, id}, value zero-extended to 10 bits):
  - g0x/g0y: {g0, 4'h1, 9'h016}, always present.
  - g1x/g1y: {g1, 4'h1, 9'h017}, present iff g0.
  - m2x/m2y: {m2, 4'h1, 9'h0BE}, present iff g1.
  - signx/signy: {sign, 4'h1, 9'h0BB}, present iff g0.
  - mvp: {(mvp_idx != 0), 4'h1, 9'h0B0}, always present.
- Emission order per list: g0x, g0y, g1x, g1y, m2x, signx, m2y, signy, mvp.
- A 4-bit slot index walks this order. A priority search selects the next present slot in the same cycle, so absent slots consume zero cycles.
- Handshake:
  - Pair is transferred when se_valid_o && se_ready_i.
  - While se_valid_o=1 && se_ready_i=0, se_pair_o holds stable.
  - se_valid_o never drops without a transfer.
  - Back-to-back transfers are allowed at one pair per cycle, including across the L0→L1 boundary (no bubble).
- start_i is ignored when not in IDLE.
- mvd = -1024 is outside the legal range. Its m2 field is the wrapped value 0x3FE, and the block does not flag it.
- rst asserted mid-PU returns to IDLE immediately. Any partially emitted PU is discarded, and no done_o is generated.

Optional Feature:
- CABAC_MVD_STAT_EN
- Defined: adds output pair_cnt_o [15:0], counting transferred pairs since reset. Saturates at 16'hFFFF, resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- L0 only, mvd=(+3,0), mvp_idx=1, ready=1 → 6 pairs, one per cycle starting at t+1: 0x2216, 0x0216, 0x2217, 0x22BE, 0x02BB, 0x22B0; done_o one cycle later.
- L0, mvd=(0,0), mvp=0 → 0x0216, 0x0216, 0x02B0, then done_o.
- BI, L0=(-1,0) mvp 0, L1=(0,+2) mvp 1 → 0x2216, 0x0216, 0x0217, 0x22BB, 0x02B0, 0x0216, 0x2216, 0x2217, 0x02BE, 0x02BB, 0x22B0, with no gap between lists.
- Random se_ready_i stalls on the BI case → identical pair sequence; se_pair_o stable during every stall; start_i pulses while busy are ignored.
- inter_dir=00 → no se_valid_o; done_o at t+1.
- rst asserted after 2 of the 6 pairs in the first case → all outputs return to reset values; a new start emits the full 6-pair sequence. With CABAC_MVD_STAT_EN, pair_cnt_o=0 after reset and 6 after this start.
